// File: rtl/sdp_rdma_req_gen.sv
// sdp_rdma_req_gen: SDP read-DMA line request generator.
// Walks surfaces x lines, credit-limited issue, layer done/stall.
module sdp_rdma_req_gen #(
  parameter int AW      = 64,
  parameter int SW      = 15,
  parameter int CW      = 13,
  parameter int MAX_OUT = 16,
  parameter int OW      = $clog2(MAX_OUT+1)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          reg2dp_op_en,
  input  logic [AW-1:0] reg2dp_base_addr,
  input  logic [AW-1:0] reg2dp_line_stride,
  input  logic [AW-1:0] reg2dp_surf_stride,
  input  logic [SW-1:0] reg2dp_size_m1,
  input  logic [CW-1:0] reg2dp_height_m1,
  input  logic [CW-1:0] reg2dp_surf_m1,
  input  logic          reg2dp_ram_type,
  input  logic          reg2dp_perf_en,
  output logic          mc_req_valid,
  input  logic          mc_req_ready,
  output logic          cv_req_valid,
  input  logic          cv_req_ready,
  output logic [AW+SW-1:0] req_pd,
  input  logic          rsp_line_done,
  output logic          dp2reg_done,
  output logic [31:0]   dp2reg_stall,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  state_t        state_q;
  logic [AW-1:0] line_stride_q;
  logic [AW-1:0] surf_stride_q;
  logic [AW-1:0] addr_line_q;
  logic [AW-1:0] addr_surf_q;
  logic [SW-1:0] size_q;
  logic [CW-1:0] height_q;
  logic [CW-1:0] surf_q;
  logic [CW-1:0] line_cnt_q;
  logic [CW-1:0] surf_cnt_q;
  logic          type_q;
  logic          perf_q;
  logic          mc_vld_q;
  logic          cv_vld_q;
  logic          done_q;
  logic [31:0]   stall_q;
  logic [OW-1:0] out_q;
  logic [OW-1:0] out_d;

  logic          sel_rdy;
  logic          vld;
  logic          accept;
  logic          last;
  logic          op_load;
  logic          credit_ok;
  logic [AW-1:0] surf_nxt;

  // handshake, walk-end and post-edge credit evaluation
  always_comb begin
    sel_rdy  = type_q ? mc_req_ready : cv_req_ready;
    vld      = mc_vld_q | cv_vld_q;
    accept   = vld & sel_rdy;
    last     = (line_cnt_q == height_q) &&
               (surf_cnt_q == surf_q);
    op_load  = reg2dp_op_en && (state_q == IDLE);
    surf_nxt = addr_surf_q + surf_stride_q;
    out_d    = out_q;
    if (accept && !rsp_line_done)
      out_d = out_q + OW'(1);
    else if (!accept && rsp_line_done &&
             out_q != '0)
      out_d = out_q - OW'(1);
    credit_ok = out_d < OW'(MAX_OUT);
  end

  // outstanding request window
  always_ff @(posedge nvdla_core_clk or
              negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) out_q <= '0;
    else                  out_q <= out_d;
  end

  // saturating backpressure counter, cleared per layer
  always_ff @(posedge nvdla_core_clk or
              negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)
      stall_q <= '0;
    else if (op_load)
      stall_q <= '0;
    else if (vld && !sel_rdy && perf_q &&
             stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end

  // layer FSM: latch, walk lines, drain credits, pulse done
  always_ff @(posedge nvdla_core_clk or
              negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q       <= IDLE;
      line_stride_q <= '0;
      surf_stride_q <= '0;
      addr_line_q   <= '0;
      addr_surf_q   <= '0;
      size_q        <= '0;
      height_q      <= '0;
      surf_q        <= '0;
      line_cnt_q    <= '0;
      surf_cnt_q    <= '0;
      type_q        <= 1'b0;
      perf_q        <= 1'b0;
      mc_vld_q      <= 1'b0;
      cv_vld_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (reg2dp_op_en) begin
          line_stride_q <= reg2dp_line_stride;
          surf_stride_q <= reg2dp_surf_stride;
          addr_line_q   <= reg2dp_base_addr;
          addr_surf_q   <= reg2dp_base_addr;
          size_q        <= reg2dp_size_m1;
          height_q      <= reg2dp_height_m1;
          surf_q        <= reg2dp_surf_m1;
          line_cnt_q    <= '0;
          surf_cnt_q    <= '0;
          type_q        <= reg2dp_ram_type;
          perf_q        <= reg2dp_perf_en;
          mc_vld_q      <= reg2dp_ram_type & credit_ok;
          cv_vld_q      <= !reg2dp_ram_type & credit_ok;
          state_q       <= RUN;
        end
        RUN: begin
          if (accept) begin
            if (line_cnt_q < height_q) begin
              line_cnt_q  <= line_cnt_q + 1'b1;
              addr_line_q <= addr_line_q + line_stride_q;
            end else begin
              line_cnt_q  <= '0;
              surf_cnt_q  <= surf_cnt_q + 1'b1;
              addr_surf_q <= surf_nxt;
              addr_line_q <= surf_nxt;
            end
          end
          if (accept && last) begin
            mc_vld_q <= 1'b0;
            cv_vld_q <= 1'b0;
            state_q  <= DRAIN;
          end else if (!vld || accept) begin
            mc_vld_q <= type_q & credit_ok;
            cv_vld_q <= !type_q & credit_ok;
          end
        end
        DRAIN: if (out_q == '0) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mc_req_valid = mc_vld_q;
  assign cv_req_valid = cv_vld_q;
  assign req_pd       = {size_q, addr_line_q};
  assign dp2reg_done  = done_q;
  assign dp2reg_stall = stall_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sdp_rdma_req_gen.sv
// tb_sdp_rdma_req_gen: randomized bench for the SDP request generator
// expected addresses come from a surface/line arithmetic model.
module tb_sdp_rdma_req_gen;

  localparam int AW = 32;
  localparam int SW = 15;
  localparam int CW = 13;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          op_en;
  logic [AW-1:0] base, ls, ss;
  logic [SW-1:0] size;
  logic [CW-1:0] hgt, srf;
  logic          rtype, perf;
  logic          mc_v, cv_v, mc_r, cv_r;
  logic [AW+SW-1:0] pd;
  logic          rsp, done, busy;
  logic [31:0]   stall;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];

  sdp_rdma_req_gen #(
    .AW(AW), .SW(SW), .CW(CW), .MAX_OUT(MO)
  ) dut (
    .nvdla_core_clk     (clk),
    .nvdla_core_rstn    (rstn),
    .reg2dp_op_en       (op_en),
    .reg2dp_base_addr   (base),
    .reg2dp_line_stride (ls),
    .reg2dp_surf_stride (ss),
    .reg2dp_size_m1     (size),
    .reg2dp_height_m1   (hgt),
    .reg2dp_surf_m1     (srf),
    .reg2dp_ram_type    (rtype),
    .reg2dp_perf_en     (perf),
    .mc_req_valid       (mc_v),
    .mc_req_ready       (mc_r),
    .cv_req_valid       (cv_v),
    .cv_req_ready       (cv_r),
    .req_pd             (pd),
    .rsp_line_done      (rsp),
    .dp2reg_done        (done),
    .dp2reg_stall       (stall),
    .busy               (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_exp();
    exp_q.delete();
    for (int s = 0; s <= int'(srf); s++)
      for (int l = 0; l <= int'(hgt); l++)
        exp_q.push_back(base + AW'(s) * ss +
                        AW'(l) * ls);
  endtask

  task automatic run_layer(
    input logic [AW-1:0] b, l_s, s_s,
    input logic [SW-1:0] sz,
    input logic [CW-1:0] h, s,
    input logic ty, pf,
    input int rlat, stall1, rnd,
    input string nm);
    int due[$];
    int out_m = 0, cyc = 0, ndone = 0;
    int exp_stall = 0, acc = 0, nexp;
    int hold = stall1;
    logic v, o, r;
    logic prev_hold = 1'b0;
    logic [AW+SW-1:0] prev_pd = '0;
    logic [AW-1:0] ea;
    base = b; ls = l_s; ss = s_s; size = sz;
    hgt = h; srf = s; rtype = ty; perf = pf;
    fill_exp();
    nexp = exp_q.size();
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
    checks++;
    if ((ty ? mc_v : cv_v) !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s first_valid got=%b busy=%b exp=1",
               nm, ty ? mc_v : cv_v, busy);
    end
    while (ndone == 0 && cyc < 4000) begin
      v = ty ? mc_v : cv_v;
      o = ty ? cv_v : mc_v;
      checks++;
      if (o !== 1'b0) begin
        failures++;
        $display("FAIL %s other_port got=%b exp=0", nm, o);
      end
      if (prev_hold) begin
        checks++;
        if (pd !== prev_pd || v !== 1'b1) begin
          failures++;
          $display("FAIL %s hold pd=%h v=%b exp pd=%h v=1",
                   nm, pd, v, prev_pd);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (out_m != 0 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL %s early_done out=%0d left=%0d exp=0",
                   nm, out_m, exp_q.size());
        end
        checks++;
        if (stall !== exp_stall) begin
          failures++;
          $display("FAIL %s stall got=%0d exp=%0d",
                   nm, stall, exp_stall);
        end
      end
      if (v && hold > 0) begin
        r = 1'b0;
        hold--;
      end else begin
        r = rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (v && !r && pf) exp_stall++;
      rsp = due.size() > 0 && due[0] <= cyc;
      if (rsp) begin
        void'(due.pop_front());
        out_m--;
      end
      if (v && r) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_req pd=%h exp=none", nm, pd);
        end else begin
          ea = exp_q.pop_front();
          if (pd !== {sz, ea}) begin
            failures++;
            $display("FAIL %s req_pd got=%h exp=%h",
                     nm, pd, {sz, ea});
          end
        end
        due.push_back(cyc + rlat);
        out_m++;
        acc++;
      end
      checks++;
      if (out_m > MO) begin
        failures++;
        $display("FAIL %s credit out=%0d max=%0d", nm, out_m, MO);
      end
      prev_hold = v && !r;
      prev_pd = pd;
      mc_r = r;
      cv_r = r;
      tick();
      cyc++;
    end
    rsp = 1'b0;
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL %s timeout done=%0d exp=1", nm, ndone);
    end
    checks++;
    if (acc != nexp) begin
      failures++;
      $display("FAIL %s accepts got=%0d exp=%0d", nm, acc, nexp);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 ||
        stall !== exp_stall) begin
      failures++;
      $display("FAIL %s after_done done=%b busy=%b stall=%0d exp 0/0/%0d",
               nm, done, busy, stall, exp_stall);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({mc_v, cv_v, pd, done, stall, busy} !== '0) begin
      failures++;
      $display("FAIL reset outputs got=%h exp=0",
               {mc_v, cv_v, pd, done, stall, busy});
    end
    rstn = 1'b1;
    tick();
    tick();
    checks++;
    if ({mc_v, cv_v, done, busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0000",
               {mc_v, cv_v, done, busy});
    end
  endtask

  task automatic test_basic_walk();
    run_layer(32'h1000, 32'h100, 32'h1000, 15'd7,
              13'd2, 13'd1, 1'b1, 1'b1, 4, 0, 0, "walk");
  endtask

  task automatic test_credit();
    int acc = 0, out_m, c, seen = 0;
    base = $urandom & ~32'h1f;
    ls = 32'h40; ss = 32'h1000; size = 15'd3;
    hgt = 13'd9; srf = 13'd0; rtype = 1'b1; perf = 1'b0;
    fill_exp();
    mc_r = 1'b1; cv_r = 1'b1; rsp = 1'b0;
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mc_v) begin
        acc++;
        checks++;
        if (pd !== {size, exp_q[0]}) begin
          failures++;
          $display("FAIL credit_pd got=%h exp=%h",
                   pd, {size, exp_q[0]});
        end
        void'(exp_q.pop_front());
      end
      tick();
    end
    checks++;
    if (acc != MO || mc_v !== 1'b0) begin
      failures++;
      $display("FAIL credit_limit accepts=%0d v=%b exp=%0d/0",
               acc, mc_v, MO);
    end
    rsp = 1'b1;
    tick();
    checks++;
    if (mc_v !== 1'b1 || pd !== {size, exp_q[0]}) begin
      failures++;
      $display("FAIL credit_release v=%b pd=%h exp=1 %h",
               mc_v, pd, {size, exp_q[0]});
    end
    void'(exp_q.pop_front());
    tick();
    rsp = 1'b0;
    checks++;
    if (mc_v !== 1'b1 || pd !== {size, exp_q[0]}) begin
      failures++;
      $display("FAIL simul_acc_rsp v=%b pd=%h exp=1 %h",
               mc_v, pd, {size, exp_q[0]});
    end
    void'(exp_q.pop_front());
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mc_v !== 1'b0) begin
        failures++;
        $display("FAIL credit_full v=%b exp=0", mc_v);
      end
      tick();
    end
    out_m = MO;
    for (c = 0; c < 200 && seen == 0; c++) begin
      if (done) begin
        seen = 1;
      end else begin
        rsp = out_m > 0;
        if (mc_v) begin
          checks++;
          if (exp_q.size() == 0 || pd !== {size, exp_q[0]}) begin
            failures++;
            $display("FAIL credit_drain pd=%h left=%0d",
                     pd, exp_q.size());
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          out_m++;
        end
        if (rsp) out_m--;
        tick();
      end
    end
    rsp = 1'b0;
    checks++;
    if (seen == 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL credit_done seen=%0d left=%0d exp=1/0",
               seen, exp_q.size());
    end
    tick();
  endtask

  task automatic test_stall();
    run_layer($urandom & ~32'h1f, 32'h80, 32'h800, 15'd2,
              13'd2, 13'd0, 1'b0, 1'b1, 3, 37, 0, "stall_on");
    checks++;
    if (stall !== 32'd37) begin
      failures++;
      $display("FAIL stall37 got=%0d exp=37", stall);
    end
    run_layer($urandom & ~32'h1f, 32'h80, 32'h800, 15'd2,
              13'd2, 13'd0, 1'b0, 1'b0, 3, 37, 0, "stall_off");
    checks++;
    if (stall !== 32'd0) begin
      failures++;
      $display("FAIL stall_off got=%0d exp=0", stall);
    end
  endtask

  task automatic test_underflow();
    rsp = 1'b1;
    tick();
    tick();
    tick();
    rsp = 1'b0;
    run_layer(32'h3000, 32'h20, 32'h400, 15'd1,
              13'd3, 13'd1, 1'b1, 1'b0, 2, 0, 0, "underflow");
  endtask

  task automatic test_wrap();
    run_layer(32'hFFFF_FF00, 32'h200, 32'h1000, 15'd0,
              13'd2, 13'd0, 1'b1, 1'b0, 3, 0, 0, "wrap");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_layer($urandom & ~32'h1f, $urandom & ~32'h1f,
                $urandom & ~32'h1f, SW'($urandom),
                CW'($urandom_range(0, 4)),
                CW'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom),
                $urandom_range(1, 8), $urandom_range(0, 5),
                1, "random");
  endtask

  task automatic test_back_to_back();
    int out_m = 0, seen = 0;
    base = 32'h4000; ls = 32'h20; ss = 32'h400;
    size = 15'd1; hgt = 13'd1; srf = 13'd0;
    rtype = 1'b0; perf = 1'b0;
    fill_exp();
    mc_r = 1'b1; cv_r = 1'b1; rsp = 1'b0;
    op_en = 1'b1;
    tick();
    base = 32'h8000;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      if (done) begin
        seen = 1;
      end else begin
        rsp = out_m > 0;
        if (cv_v) begin
          checks++;
          if (exp_q.size() == 0 || pd !== {size, exp_q[0]}) begin
            failures++;
            $display("FAIL b2b_first pd=%h left=%0d",
                     pd, exp_q.size());
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          out_m++;
        end
        if (rsp) out_m--;
        tick();
      end
    end
    rsp = 1'b0;
    checks++;
    if (seen == 0) begin
      failures++;
      $display("FAIL b2b_timeout done=0 exp=1");
    end
    tick();
    checks++;
    if (cv_v !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap v=%b exp=0", cv_v);
    end
    tick();
    op_en = 1'b0;
    fill_exp();
    checks++;
    if (cv_v !== 1'b1 || pd !== {size, exp_q[0]}) begin
      failures++;
      $display("FAIL b2b_restart v=%b pd=%h exp=1 %h",
               cv_v, pd, {size, exp_q[0]});
    end
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      if (done) begin
        seen = 1;
      end else begin
        rsp = out_m > 0;
        if (cv_v) begin
          checks++;
          if (exp_q.size() == 0 || pd !== {size, exp_q[0]}) begin
            failures++;
            $display("FAIL b2b_second pd=%h left=%0d",
                     pd, exp_q.size());
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          out_m++;
        end
        if (rsp) out_m--;
        tick();
      end
    end
    rsp = 1'b0;
    checks++;
    if (seen == 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_done seen=%0d left=%0d exp=1/0",
               seen, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    base = 32'h5000; ls = 32'h20; ss = 32'h400;
    size = 15'd4; hgt = 13'd5; srf = 13'd1;
    rtype = 1'b1; perf = 1'b1;
    mc_r = 1'b0; cv_r = 1'b0;
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
    tick();
    tick();
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({mc_v, cv_v, pd, done, stall, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=0",
               {mc_v, cv_v, pd, done, stall, busy});
    end
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if ({mc_v, cv_v, busy} !== 3'b0) begin
      failures++;
      $display("FAIL reset_release got=%b exp=000",
               {mc_v, cv_v, busy});
    end
  endtask

  initial begin
    op_en = 1'b0; base = '0; ls = '0; ss = '0;
    size = '0; hgt = '0; srf = '0;
    rtype = 1'b0; perf = 1'b0;
    mc_r = 1'b0; cv_r = 1'b0; rsp = 1'b0;
    tick();
    tick();
    test_reset();
    test_basic_walk();
    test_credit();
    test_stall();
    test_underflow();
    test_wrap();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
